// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: 16-bit stereo pairs from a small FIFO serialised onto
// bclk/lrclk/sdata, with bclk and lrclk derived from the system clock.
module i2s_transmitter #(
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic [15:0]                 left_in,
  input  logic [15:0]                 right_in,
  input  logic                        underflow_clr,
  output logic                        underflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        bclk,
  output logic                        lrclk,
  output logic                        sdata
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned KW = 5;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } pair_t;

  pair_t          mem [FIFO_DEPTH];
  pair_t          head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [DW-1:0]  div;
  logic [KW-1:0]  bit_k;
  logic [31:0]    shift;
  logic           held_r0;

  logic push;
  logic pop;
  logic tick;
  logic fall_ev;
  logic frame_start;
  logic fifo_empty;

  assign sample_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_level == '0);
  assign push         = sample_valid && sample_ready;
  assign tick         = enable && (div == DW'(CLK_DIV - 1));
  assign fall_ev      = tick && bclk;
  assign frame_start  = fall_ev && (bit_k == '0);
  // Emptiness is judged before this cycle's push, so a same-cycle push cannot rescue slot 0.
  assign pop          = frame_start && !fifo_empty;
  assign head         = mem[rd_ptr];

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= pair_t'({left_in, right_in});
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky underflow; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      underflow <= 1'b0;
    end else if (frame_start && fifo_empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  // Bit clock divider and serialiser; serial outputs move only on bclk falls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div     <= '0;
      bclk    <= 1'b0;
      bit_k   <= '0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
      shift   <= '0;
      held_r0 <= 1'b0;
    end else if (!enable) begin
      div     <= '0;
      bclk    <= 1'b0;
      bit_k   <= '0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
      shift   <= '0;
      held_r0 <= 1'b0;
    end else begin
      if (tick) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + DW'(1);
      end
      if (fall_ev) begin
        bit_k <= bit_k + KW'(1);
        lrclk <= bit_k[KW-1];
        if (bit_k == '0) begin
          // Slot 0 carries the previous right sample's LSB (Philips one-bit delay).
          sdata <= held_r0;
          if (pop) begin
            shift   <= head;
            held_r0 <= head.right[0];
          end else begin
            shift   <= '0;
            held_r0 <= 1'b0;
          end
        end else begin
          sdata <= shift[31];
          shift <= {shift[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed-plus-random bench for i2s_transmitter: decodes the serial stream on bclk
// rising edges and compares whole frames against the expected pair sequence.
module tb_i2s_transmitter;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        enable;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        underflow_clr;
  logic        underflow;
  logic [2:0]  fifo_level;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  i2s_transmitter #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .left_in(left_in), .right_in(right_in),
    .underflow_clr(underflow_clr), .underflow(underflow),
    .fifo_level(fifo_level), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Receiver side: {lrclk, sdata} captured at each bclk rise, starting with slot 0.
  logic [1:0] rx[$];
  logic       armed     = 1'b0;
  logic       prev_bclk = 1'b0;

  always @(negedge clock) begin
    if (!resetn || !enable) begin
      armed <= 1'b0;
    end else begin
      if (prev_bclk && !bclk) armed <= 1'b1;
      if (!prev_bclk && bclk && armed) rx.push_back({lrclk, sdata});
    end
    prev_bclk <= bclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int b = 0;
    while (rx.size() < n && b < 8000) begin
      tick();
      b++;
    end
    chk(tag, 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic wait_bclk(input logic v, output int cnt);
    cnt = 0;
    while (bclk !== v && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    sample_valid = 1'b1;
    left_in      = l;
    right_in     = r;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
  endtask

  // Captured frame f as a 32-bit word, slot 0 in bit 31; b selects sdata(0) or lrclk(1).
  function automatic logic [31:0] word_of(input int f, input int b);
    logic [31:0] w;
    for (int j = 0; j < 32; j++) w[31-j] = rx[32*f + j][b];
    return w;
  endfunction

  // Expected slot order: previous right LSB, then L[15:0], then R[15:1].
  function automatic logic [31:0] exp_word(input logic [31:0] pair, input logic prev_r0);
    return {prev_r0, pair[31:1]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic [31:0] exp_q[$];
    logic [31:0] lrw;
    logic [15:0] l;
    logic [15:0] r;
    logic        rdy;
    logic        seen256;
    logic        seen257;
    int          c0;
    int          c1;
    int          acc;
    int          b;
    int          ready_early;

    lrw           = 32'h0000_FFFF;
    resetn        = 1'b0;
    enable        = 1'b0;
    sample_valid  = 1'b0;
    underflow_clr = 1'b0;
    left_in       = '0;
    right_in      = '0;

    // Reset state
    #12;
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", sample_ready, 1);
    tick();
    resetn = 1'b1;
    tick();

    // One known pair, then an underflowing frame
    p = {16'hA5A5, 16'h5A5A};
    push_pair(p[31:16], p[15:0]);
    chk("t1_level", fifo_level, 1);
    rx.delete();
    enable = 1'b1;
    wait_bclk(1'b1, c0);
    chk("t1_first_rise", c0, CLK_DIV);
    wait_bclk(1'b0, c0);
    chk("t1_first_fall", c0, CLK_DIV);
    chk("t1_pop_level", fifo_level, 0);
    chk("t1_ready_after_pop", sample_ready, 1);
    wait_bclk(1'b1, c0);
    wait_bclk(1'b0, c1);
    chk("t1_bclk_period", c0 + c1, 2 * CLK_DIV);
    wait_rx(32, "t1_wait_f0");
    chk("t1_no_underflow", underflow, 0);
    wait_rx(64, "t1_wait_f1");
    chk("t1_f0_data", word_of(0, 0), exp_word(p, 1'b0));
    chk("t1_f0_lrclk", word_of(0, 1), lrw);
    chk("t1_f1_data", word_of(1, 0), exp_word(32'h0, p[0]));
    chk("t1_underflow", underflow, 1);

    // Disable idles the outputs; clear works
    enable = 1'b0;
    tick();
    chk("t2_idle_bclk", bclk, 0);
    chk("t2_idle_lrclk", lrclk, 0);
    chk("t2_idle_sdata", sdata, 0);
    chk("t2_underflow_held", underflow, 1);
    pulse_clr();
    chk("t2_underflow_clr", underflow, 0);

    // Empty FIFO: clear coincident with the slot-0 set must lose
    rx.delete();
    enable = 1'b1;
    repeat (3) tick();
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("t3_at_fall", bclk, 0);
    chk("t3_set_wins", underflow, 1);
    wait_rx(32, "t3_wait_f0");
    chk("t3_f0_zero", word_of(0, 0), 32'h0);
    chk("t3_f0_lrclk", word_of(0, 1), lrw);
    enable = 1'b0;
    tick();
    pulse_clr();
    chk("t3_cleared", underflow, 0);

    // Fill with 5 back-to-back pushes while disabled; only FIFO_DEPTH accepted
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      l   = 16'($urandom);
      r   = 16'($urandom);
      rdy = sample_ready;
      sample_valid = 1'b1;
      left_in      = l;
      right_in     = r;
      tick();
      if (rdy) begin
        acc++;
        exp_q.push_back({l, r});
        if (acc == FIFO_DEPTH) begin
          chk("t4_ready_full", sample_ready, 0);
          chk("t4_level_full", fifo_level, FIFO_DEPTH);
        end
      end
    end
    sample_valid = 1'b0;
    chk("t4_accepted", acc, FIFO_DEPTH);
    chk("t4_level_kept", fifo_level, FIFO_DEPTH);

    // Enable: ready returns only once the first pop has happened
    rx.delete();
    enable      = 1'b1;
    b           = 0;
    ready_early = 0;
    while (fifo_level == 3'(FIFO_DEPTH) && b < 100) begin
      if (sample_ready) ready_early++;
      tick();
      b++;
    end
    chk("t4_ready_early", ready_early, 0);
    chk("t4_level_pop", fifo_level, FIFO_DEPTH - 1);
    chk("t4_ready_pop", sample_ready, 1);

    // Keep the FIFO topped up with random pairs until 8 are sent
    seen256 = 1'b0;
    seen257 = 1'b0;
    b       = 0;
    while (rx.size() < 288 && b < 8000) begin
      if (!seen256 && rx.size() == 256) begin
        seen256 = 1'b1;
        chk("t4_no_underflow", underflow, 0);
      end
      if (!seen257 && rx.size() >= 257) begin
        seen257 = 1'b1;
        chk("t4_underflow_end", underflow, 1);
      end
      if (exp_q.size() < 8 && sample_ready) begin
        l = 16'($urandom);
        r = 16'($urandom);
        sample_valid = 1'b1;
        left_in      = l;
        right_in     = r;
        exp_q.push_back({l, r});
      end else begin
        sample_valid = 1'b0;
      end
      tick();
      b++;
    end
    sample_valid = 1'b0;
    chk("t4_rx_count", 32'(rx.size() >= 288), 1);
    for (int f = 0; f < 9; f++) begin
      logic [31:0] cur;
      logic        prv;
      cur = (f < 8) ? exp_q[f] : 32'h0;
      prv = (f == 0) ? 1'b0 : exp_q[f-1][0];
      chk($sformatf("t4_f%0d_data", f), word_of(f, 0), exp_word(cur, prv));
      chk($sformatf("t4_f%0d_lrclk", f), word_of(f, 1), lrw);
    end

    // Asynchronous reset mid-frame with pairs queued
    enable = 1'b0;
    tick();
    pulse_clr();
    for (int i = 0; i < 3; i++) push_pair(16'($urandom), 16'($urandom));
    rx.delete();
    enable = 1'b1;
    wait_rx(21, "t5_wait_mid");
    chk("t5_pre_lrclk", lrclk, 1);
    chk("t5_pre_level", fifo_level, 2);
    resetn = 1'b0;
    #1;
    chk("t5_rst_bclk", bclk, 0);
    chk("t5_rst_lrclk", lrclk, 0);
    chk("t5_rst_sdata", sdata, 0);
    chk("t5_rst_level", fifo_level, 0);
    chk("t5_rst_ready", sample_ready, 1);
    chk("t5_rst_underflow", underflow, 0);
    tick();
    resetn = 1'b1;
    rx.delete();
    l = 16'($urandom);
    r = 16'($urandom);
    push_pair(l, r);
    chk("t5_level_after", fifo_level, 1);
    wait_rx(32, "t5_wait_f0");
    chk("t5_f0_data", word_of(0, 0), exp_word({l, r}, 1'b0));
    chk("t5_f0_lrclk", word_of(0, 1), lrw);
    chk("t5_no_underflow", underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Upstream stage of the I2S receiver: serialises 16-bit stereo sample pairs onto bclk/lrclk/sdata in Philips I2S format.
- Generates bclk and lrclk itself from the system clock.
- Buffers pairs in a small FIFO fed by a valid/ready handshake from the audio DMA or CPU register path.
- Intended for the audio output pins and for on-chip loopback into the receiver in simulation.

Parameters:
- CLK_DIV, 8, system clocks per bclk half-period (≥2); bit period = 2*CLK_DIV clocks, frame = 64*CLK_DIV clocks.
- FIFO_DEPTH, 4, stereo-pair entries (power of 2, ≥2).

Ports:
- clock  input  1  system clock; all logic on posedge.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  1 = run the serial interface; 0 = idle.
- sample_valid  input  1  producer has a pair on left_in/right_in.
- sample_ready  output  1  FIFO can accept a pair (= not full).
- left_in  input  16  signed left sample.
- right_in  input  16  signed right sample.
- underflow_clr  input  1  clears underflow.
- underflow  output  1  sticky: a frame started with FIFO empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently held.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  0 = left, 1 = right.
- sdata  output  1  serial data, MSB first.

Behaviour:
- Reset (async, resetn=0):
  - bclk, lrclk, sdata = 0; underflow = 0; FIFO empty; fifo_level = 0; sample_ready = 1.
  - Divider, bit counter and shift register cleared; held_r0 = 0.
  - Applies instantly mid-frame; FIFO contents are discarded.
- Push: on a clock where sample_valid && sample_ready, {left_in, right_in} is written. sample_ready = (fifo_level != FIFO_DEPTH), combinational from the level count.
- Divider:
  - While enable=1, the divider counts 0..CLK_DIV-1; at terminal count, bclk toggles.
  - A rising toggle is a rise event. A falling toggle is a fall event.
- Frame bit counter k (0..31): advances by 1 at each fall event and wraps 31→0.
- All outputs are registered and update only on fall events, so the receiver samples mid-bit on bclk rising.
- Output at the fall event with counter value k:
  - lrclk = 0 for k=0..15; 1 for k=16..31.
  - k=0: sdata = held_r0 (bit 0 of the previous right sample; 0 on the first frame after enable or reset). A FIFO pop occurs in this same clock if non-empty. The popped pair loads the 32-bit shift register, and R[0] is saved to held_r0 for the next frame.
  - k=1..16: sdata = L[15]..L[0].
  - k=17..31: sdata = R[15]..R[1].
  - The MSB of each channel therefore follows the lrclk transition by one bit.
- Underflow: if the FIFO is empty at k=0, the shift register loads 0 and held_r0 is set to 0. underflow is set and stays set until underflow_clr=1. If set and clear occur in the same cycle, set wins.
- Push and pop in the same cycle:
  - The level is unchanged.
  - When full, the push is refused because sample_ready=0; ready rises the cycle after the pop.
  - When empty at k=0, a same-cycle push is not popped; that frame underflows.
- enable deasserted:
  - Divider and k reset to 0; bclk, lrclk, sdata forced 0 on the next clock.
  - FIFO retained and pushes still accepted.
  - On re-enable, the first fall event is k=0 and pops immediately; this first fall is produced CLK_DIV clocks after bclk first rises.
- fifo_level wraps never; read/write pointers are FIFO_DEPTH-modulo with a separate count.

Test Plan:
- CLK_DIV=2, push L=16'hA5A5 R=16'h5A5A, enable=1 -> rise-sampled sdata over frame is 0,A5A5 bits MSB-first during lrclk=0 (after first slot), 5A5A bits [15:1] during lrclk=1, next frame slot 0 = 0; bclk period 4 clocks.
- Push 5 pairs back-to-back with enable=0 -> first 4 accepted, sample_ready=0 from the 4th accept, fifo_level=4; enable -> ready returns 1 the cycle after the first pop.
- Enable with empty FIFO -> sdata constant 0 for all 32 bits, underflow=1 after k=0; pulse underflow_clr -> 0; set+clr same cycle -> stays 1.
- Assert resetn=0 at k=20 with 2 pairs queued -> all outputs 0 immediately, fifo_level=0, ready=1; after release with enable=1, frame restarts at k=0.
- Loopback into the I2S receiver with pairs (16'h7FFF, 16'h8000), (16'h1234, -16'sd1) -> receiver left/right outputs reproduce each pair in order, no underflow while the FIFO is kept non-empty.
